// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU datapath: operand widths, opcode map
// and the command sequencer state encoding.
package alu_pkg;

    localparam int ALU_IN_W  = 4;
    localparam int ALU_OUT_W = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_INC = 3'b110;
    localparam logic [2:0] OP_DEC = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of an external combinational ALU: registers
// operands, waits one cycle for the ALU to settle, then returns the result.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int TAG_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ALU_IN_W-1:0]  cmd_a,
    input  logic [ALU_IN_W-1:0]  cmd_b,
    input  logic [2:0]           cmd_sel,
    input  logic                 cmd_chain,
    input  logic [TAG_W-1:0]     cmd_tag,
    output logic [ALU_IN_W-1:0]  alu_a,
    output logic [ALU_IN_W-1:0]  alu_b,
    output logic [2:0]           alu_sel,
    input  logic [ALU_OUT_W-1:0] alu_out,
    input  logic                 alu_zero,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ALU_OUT_W-1:0] rsp_data,
    output logic                 rsp_zero,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic [CNT_W-1:0]     op_count
);

    seq_state_e           state_q, state_d;
    logic [ALU_IN_W-1:0]  a_q, a_d;
    logic [ALU_IN_W-1:0]  b_q, b_d;
    logic [2:0]           sel_q, sel_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [ALU_OUT_W-1:0] rsp_data_q, rsp_data_d;
    logic                 rsp_zero_q, rsp_zero_d;
    logic [TAG_W-1:0]     rsp_tag_q, rsp_tag_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ALU_OUT_W-1:0] last_q, last_d;

    // Handshake flags come from state only, so rsp_ready never reaches cmd_ready.
    assign cmd_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sel_d      = sel_q;
        tag_d      = tag_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        rsp_tag_d  = rsp_tag_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    a_d     = cmd_chain ? last_q[ALU_IN_W-1:0] : cmd_a;
                    b_d     = cmd_b;
                    sel_d   = cmd_sel;
                    tag_d   = cmd_tag;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d = alu_out;
                rsp_zero_d = alu_zero;
                rsp_tag_d  = tag_q;
                last_d     = alu_out;
                state_d    = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= '0;
            tag_q      <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            rsp_tag_q  <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sel_q      <= sel_d;
            tag_q      <= tag_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_tag_q  <= rsp_tag_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_sel  = sel_q;
    assign rsp_data = rsp_data_q;
    assign rsp_zero = rsp_zero_q;
    assign rsp_tag  = rsp_tag_q;
    assign op_count = cnt_q;

endmodule
